// File: rtl/sevenseg_scan.sv
// Multiplexed hex display scanner feeding a sevenseg decoder.
// Scans NDIGITS nibbles with an anode-off ghost gap at the start of each slot.
// It can blank leading zeros. New values are held in a pending register and
// committed at the frame wrap, so a frame is never drawn with mixed values.
module sevenseg_scan #(
  parameter int unsigned NDIGITS     = 4,
  parameter int unsigned REFRESH_DIV = 50000,
  parameter int unsigned GHOST_CYC   = 500
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       load,
  input  logic [4*NDIGITS-1:0]       value,
  input  logic                       lzb,
  output logic [3:0]                 data,
  output logic [NDIGITS-1:0]         anode_n,
  output logic [$clog2(NDIGITS)-1:0] digit_sel,
  output logic                       update_pending,
  output logic                       frame_done
);

  localparam int unsigned VW = 4 * NDIGITS;
  localparam int unsigned SW = $clog2(NDIGITS);
  localparam int unsigned CW = $clog2(REFRESH_DIV);

  logic [CW-1:0]      cnt;
  logic [VW-1:0]      shadow;
  logic [VW-1:0]      pending;

  logic               slot_end;
  logic               wrap;
  logic [CW-1:0]      cnt_nxt;
  logic [SW-1:0]      sel_nxt;
  logic [VW-1:0]      shadow_nxt;
  logic [VW-1:0]      pending_nxt;
  logic               pflag_nxt;
  logic [NDIGITS-1:0] blank_vec;
  logic               hi_zero;
  logic [3:0]         data_nxt;
  logic [NDIGITS-1:0] anode_nxt;

  // Slot/digit counters and the load/commit path for the pending and shadow registers
  always_comb begin
    slot_end    = (cnt == CW'(REFRESH_DIV - 1));
    wrap        = slot_end && (digit_sel == SW'(NDIGITS - 1));
    cnt_nxt     = slot_end ? '0 : cnt + CW'(1);
    sel_nxt     = digit_sel;
    shadow_nxt  = shadow;
    pending_nxt = pending;
    pflag_nxt   = update_pending;

    if (wrap) begin
      sel_nxt = '0;
    end else if (slot_end) begin
      sel_nxt = digit_sel + SW'(1);
    end

    if (wrap) begin
      // A load coinciding with the wrap goes straight to the display
      if (load) begin
        shadow_nxt = value;
        pflag_nxt  = 1'b0;
      end else if (update_pending) begin
        shadow_nxt = pending;
        pflag_nxt  = 1'b0;
      end
    end else if (load) begin
      pending_nxt = value;
      pflag_nxt   = 1'b1;
    end
  end

  // Leading-zero blanking and the output values for the state being entered
  always_comb begin
    blank_vec = '0;
    hi_zero   = 1'b1;
    for (int i = NDIGITS - 1; i >= 1; i--) begin
      hi_zero      = hi_zero & (shadow_nxt[4*i +: 4] == 4'h0);
      blank_vec[i] = lzb & hi_zero;
    end
    data_nxt  = 4'(shadow_nxt >> {sel_nxt, 2'b00});
    anode_nxt = '1;
    if ((cnt_nxt >= CW'(GHOST_CYC)) && !blank_vec[sel_nxt]) begin
      anode_nxt = ~(NDIGITS'(1) << sel_nxt);
    end
  end

  // State and registered outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt            <= '0;
      digit_sel      <= '0;
      shadow         <= '0;
      pending        <= '0;
      update_pending <= 1'b0;
      data           <= '0;
      anode_n        <= '1;
      frame_done     <= 1'b0;
    end else begin
      cnt            <= cnt_nxt;
      digit_sel      <= sel_nxt;
      shadow         <= shadow_nxt;
      pending        <= pending_nxt;
      update_pending <= pflag_nxt;
      data           <= data_nxt;
      anode_n        <= anode_nxt;
      frame_done     <= wrap;
    end
  end

endmodule

// File: tb/tb_sevenseg_scan.sv
// Self-checking bench for sevenseg_scan with NDIGITS=4, REFRESH_DIV=8, GHOST_CYC=2.
module tb_sevenseg_scan;

  localparam int unsigned ND = 4;
  localparam int unsigned RD = 8;
  localparam int unsigned GC = 2;
  localparam int unsigned FR = ND * RD;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        load = 1'b0;
  logic [15:0] value = '0;
  logic        lzb = 1'b0;
  logic [3:0]  data;
  logic [3:0]  anode_n;
  logic [1:0]  digit_sel;
  logic        update_pending;
  logic        frame_done;

  always #5 clk = ~clk;

  sevenseg_scan #(.NDIGITS(ND), .REFRESH_DIV(RD), .GHOST_CYC(GC)) dut (
    .clk(clk),
    .reset_n(reset_n),
    .load(load),
    .value(value),
    .lzb(lzb),
    .data(data),
    .anode_n(anode_n),
    .digit_sel(digit_sel),
    .update_pending(update_pending),
    .frame_done(frame_done)
  );

  typedef struct packed {
    logic [3:0] data;
    logic [3:0] an;
    logic [1:0] sel;
    logic       up;
    logic       fd;
  } exp_t;

  typedef struct packed {
    logic        pre_en;
    logic [15:0] pre_v;
    logic [15:0] v;
    logic        lz;
    logic        at_wrap;
    logic [15:0] dat_exp;
    logic [15:0] an_exp;
  } vec_t;

  exp_t        sbq[$];
  int          checks = 0;
  int          errors = 0;
  int          t = 0;
  logic [15:0] m_sh = '0;
  logic [15:0] m_pd = '0;
  logic        m_pf = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0d)", name, act, exp, t);
    end
  endtask

  // Cycle model: position in the frame is derived from cycles since reset
  task automatic model_edge(input logic l, input logic [15:0] v);
    exp_t e;
    int   slot;
    int   ph;
    logic wr;
    logic blank;
    wr = ((t % FR) == FR - 1);
    if (wr) begin
      if (l) begin
        m_sh = v;
        m_pf = 1'b0;
      end else if (m_pf) begin
        m_sh = m_pd;
        m_pf = 1'b0;
      end
    end else if (l) begin
      m_pd = v;
      m_pf = 1'b1;
    end
    t++;
    slot  = (t / RD) % ND;
    ph    = t % RD;
    blank = (slot > 0) && lzb && ((m_sh >> (4 * slot)) == 16'h0);
    e.data = 4'((m_sh >> (4 * slot)) & 16'hF);
    e.an   = 4'hF;
    if (ph >= GC && !blank) e.an[slot] = 1'b0;
    e.sel  = 2'(slot);
    e.up   = m_pf;
    e.fd   = wr;
    sbq.push_back(e);
  endtask

  task automatic step(input logic l, input logic [15:0] v);
    exp_t e;
    load  = l;
    value = v;
    @(posedge clk);
    model_edge(l, v);
    @(negedge clk);
    load = 1'b0;
    if (sbq.size() == 0) begin
      check("scoreboard_empty", 1, 0);
    end else begin
      e = sbq.pop_front();
      check("data", data, e.data);
      check("anode_n", anode_n, e.an);
      check("digit_sel", digit_sel, e.sel);
      check("update_pending", update_pending, e.up);
      check("frame_done", frame_done, e.fd);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        vt[6];
    logic [15:0] dx;
    logic [15:0] ax;
    int          pulses;
    int          last;

    vt[0] = '{pre_en:1'b0, pre_v:16'h0,    v:16'h1234, lz:1'b0, at_wrap:1'b0, dat_exp:16'h1234, an_exp:16'h7BDE};
    vt[1] = '{pre_en:1'b1, pre_v:16'hAAAA, v:16'h5678, lz:1'b0, at_wrap:1'b0, dat_exp:16'h5678, an_exp:16'h7BDE};
    vt[2] = '{pre_en:1'b0, pre_v:16'h0,    v:16'h0040, lz:1'b1, at_wrap:1'b0, dat_exp:16'h0040, an_exp:16'hFFDE};
    vt[3] = '{pre_en:1'b0, pre_v:16'h0,    v:16'h0000, lz:1'b1, at_wrap:1'b0, dat_exp:16'h0000, an_exp:16'hFFFE};
    vt[4] = '{pre_en:1'b0, pre_v:16'h0,    v:16'h0040, lz:1'b0, at_wrap:1'b0, dat_exp:16'h0040, an_exp:16'h7BDE};
    vt[5] = '{pre_en:1'b0, pre_v:16'h0,    v:16'h9ABC, lz:1'b1, at_wrap:1'b1, dat_exp:16'h9ABC, an_exp:16'h7BDE};

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_data", data, 4'h0);
    check("rst_anode", anode_n, 4'hF);
    check("rst_sel", digit_sel, 2'd0);
    check("rst_pending", update_pending, 1'b0);
    check("rst_frame_done", frame_done, 1'b0);
    reset_n = 1'b1;

    // Table: load a value, let it commit, then check the whole next frame
    for (int n = 0; n < 6; n++) begin
      lzb = vt[n].lz;
      if (vt[n].at_wrap) begin
        while ((t % FR) != FR - 1) step(1'b0, 16'h0);
        step(1'b1, vt[n].v);
      end else begin
        while ((t % FR) != 3) step(1'b0, 16'h0);
        if (vt[n].pre_en) begin
          step(1'b1, vt[n].pre_v);
          check("pending_after_first", update_pending, 1'b1);
        end
        step(1'b1, vt[n].v);
        check("pending_set", update_pending, 1'b1);
        while ((t % FR) != 0) step(1'b0, 16'h0);
      end
      dx = vt[n].dat_exp;
      ax = vt[n].an_exp;
      for (int k = 0; k < int'(FR); k++) begin
        int s;
        s = k / RD;
        if (k == 0) begin
          check("wrap_frame_done", frame_done, 1'b1);
          check("wrap_pending_clear", update_pending, 1'b0);
        end
        if (vt[n].at_wrap) check("no_pending", update_pending, 1'b0);
        check("tbl_data", data, dx[4*s +: 4]);
        if ((k % RD) < GC) check("tbl_ghost", anode_n, 4'hF);
        else               check("tbl_anode", anode_n, ax[4*s +: 4]);
        step(1'b0, 16'h0);
      end
    end

    // Asynchronous reset mid-SHOW of slot 2, with a load still pending
    while ((t % FR) != 18) step(1'b0, 16'h0);
    step(1'b1, 16'h1111);
    while ((t % FR) != 20) step(1'b0, 16'h0);
    check("pre_reset_lit", anode_n, 4'hB);
    #2 reset_n = 1'b0;
    #1;
    check("async_anode", anode_n, 4'hF);
    check("async_data", data, 4'h0);
    check("async_sel", digit_sel, 2'd0);
    check("async_pending", update_pending, 1'b0);
    @(negedge clk);
    check("held_anode", anode_n, 4'hF);
    reset_n = 1'b1;
    t = 0; m_sh = '0; m_pd = '0; m_pf = 1'b0;
    step(1'b0, 16'h0);
    check("restart_ghost", anode_n, 4'hF);
    step(1'b0, 16'h0);
    check("restart_show", anode_n, 4'hE);

    // Free run: frame_done cadence and single-anode invariant
    lzb = 1'b0;
    pulses = 0;
    last = -1;
    for (int k = 0; k < 128; k++) begin
      step(1'b0, 16'h0);
      if (frame_done) begin
        pulses++;
        if (last >= 0) check("fd_period", 32'(t - last), 32'(FR));
        last = t;
      end
      check("one_anode", 32'($countones(~anode_n) <= 1), 32'd1);
    end
    check("fd_count", 32'(pulses), 32'd4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
